// File: rtl/beam_scan_ctrl.sv
// beam_scan_ctrl: steps the beamformer delay through NUM_STEPS settings, one energy window each,
// and reports the max-energy delay; the per-window watchdog is built only with SCAN_TIMEOUT_EN.
module beam_scan_ctrl #(
  parameter int NUM_STEPS   = 16,
  parameter int DELAY_W     = 6,
  parameter int STEER_MIN   = -8,
  parameter int ENERGY_W    = 32,
  parameter int SETTLE_CYC  = 64,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic                         s_clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         continuous,
  input  logic                         abort,
  output logic [DELAY_W-1:0]           steer_delay,
  output logic                         win_start,
  input  logic                         bf_energy_vld,
  input  logic [ENERGY_W-1:0]          bf_energy,
  output logic                         busy,
  output logic                         scan_done,
  output logic [DELAY_W-1:0]           best_delay,
  output logic [ENERGY_W-1:0]          best_energy,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         timeout_err
);
  localparam int KW = $clog2(NUM_STEPS);
  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [DELAY_W-1:0] SMIN = DELAY_W'(STEER_MIN);
  localparam logic [KW-1:0] LAST = KW'(NUM_STEPS - 1);
  if (NUM_STEPS < 2 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1 ||
      STEER_MIN < -(2**(DELAY_W-1)) || STEER_MIN + NUM_STEPS - 1 >= 2**(DELAY_W-1)) begin : g_param_err
    $error("beam_scan_ctrl: steering range or counts out of bounds");
  end
  typedef enum logic [2:0] {IDLE, SET, SETTLE, WAIT, CMP, DONE} state_t;
  state_t              state_q, state_d;
  logic [KW-1:0]       k_q, k_d, run_idx_q, run_idx_d;
  logic [DELAY_W-1:0]  steer_q, steer_d, best_delay_q, best_delay_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ENERGY_W-1:0] energy_q, energy_d, run_max_q, run_max_d, best_energy_q, best_energy_d;
  logic                terr_q, terr_d;
`ifdef SCAN_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0]       wd_q, wd_d;
  always_ff @(posedge s_clk)
    if (rst) wd_q <= '0;
    else wd_q <= wd_d;
`endif
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    steer_d = steer_q;
    cnt_d = cnt_q;
    energy_d = energy_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    best_delay_d = best_delay_q;
    best_energy_d = best_energy_q;
    terr_d = terr_q;
`ifdef SCAN_TIMEOUT_EN
    wd_d = wd_q;
`endif
    win_start = 1'b0;
    scan_done = 1'b0;
    // abort overrides everything, including start in IDLE and the DONE update
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        state_d = SET;
        k_d = '0;
        run_max_d = '0;
        run_idx_d = '0;
        terr_d = 1'b0;
      end
      SET: begin
        steer_d = SMIN + DELAY_W'(k_q);
        cnt_d = CW'(SETTLE_CYC - 1);
        state_d = SETTLE;
      end
      SETTLE: if (cnt_q == '0) begin
        win_start = 1'b1;
        state_d = WAIT;
`ifdef SCAN_TIMEOUT_EN
        wd_d = '0;
`endif
      end else cnt_d = cnt_q - 1'b1;
      WAIT: begin
        if (bf_energy_vld) begin
          energy_d = bf_energy;
          state_d = CMP;
        end
`ifdef SCAN_TIMEOUT_EN
        else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
          energy_d = '0;
          terr_d = 1'b1;
          state_d = CMP;
        end else wd_d = wd_q + 1'b1;
`endif
      end
      CMP: begin
        if (energy_q > run_max_q || k_q == '0) begin
          run_max_d = energy_q;
          run_idx_d = k_q;
        end
        state_d = (k_q == LAST) ? DONE : SET;
        k_d = (k_q == LAST) ? k_q : k_q + 1'b1;
      end
      DONE: begin
        scan_done = 1'b1;
        best_delay_d = SMIN + DELAY_W'(run_idx_q);
        best_energy_d = run_max_q;
        state_d = continuous ? SET : IDLE;
        if (continuous) begin
          k_d = '0;
          run_max_d = '0;
          run_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_clk)
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      steer_q <= SMIN;
      cnt_q <= '0;
      energy_q <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      best_delay_q <= SMIN;
      best_energy_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      steer_q <= steer_d;
      cnt_q <= cnt_d;
      energy_q <= energy_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      best_delay_q <= best_delay_d;
      best_energy_q <= best_energy_d;
      terr_q <= terr_d;
    end
  assign steer_delay = steer_q;
  assign busy = state_q != IDLE;
  assign best_delay = best_delay_q;
  assign best_energy = best_energy_q;
  assign step_idx = k_q;
  assign timeout_err = terr_q;
endmodule
